// File: rtl/dvp_timing_pkg.sv
// dvp_timing_pkg: shared state encoding and parameter defaults for the DVP sync regenerator
package dvp_timing_pkg;
  typedef enum logic [1:0] {SEARCH, MEASURE, RUN} state_t;
  localparam int DEF_HCOUNT_BITS = 12;
  localparam int DEF_VCOUNT_BITS = 11;
  localparam int DEF_HS_FRONT    = 110;
  localparam int DEF_HS_WIDTH    = 40;
  localparam int DEF_LOCK_LINES  = 4;
  localparam int DEF_HS_POL      = 1;
  localparam int MATCH_BITS      = 4;
endpackage

// File: rtl/dvp_edge_det.sv
// dvp_edge_det: registers href/vsync on the falling pixclk edge and flags their transitions
// Ports: pixclk, reset_n (async, active-low); href, vsync inputs;
//        href_d1 = href delayed one cycle; href_rise/href_fall/vsync_rise = transition flags
module dvp_edge_det (
  input  logic pixclk,
  input  logic reset_n,
  input  logic href,
  input  logic vsync,
  output logic href_d1,
  output logic href_rise,
  output logic href_fall,
  output logic vsync_rise
);
  logic vsync_d1;
  always_ff @(negedge pixclk or negedge reset_n) begin
    if (!reset_n) begin
      href_d1  <= 1'b0;
      vsync_d1 <= 1'b0;
    end else begin
      href_d1  <= href;
      vsync_d1 <= vsync;
    end
  end
  assign href_rise  = href & ~href_d1;
  assign href_fall  = ~href & href_d1;
  assign vsync_rise = vsync & ~vsync_d1;
endmodule

// File: rtl/dvp_sync_gen.sv
// dvp_sync_gen: measures DVP line/frame timing and regenerates a horizontal sync pulse
// Ports: pixclk (state on falling edge), reset_n (async, active-low), vsync, href inputs;
//        o_hsync regenerated sync, o_de = href delayed, o_h_total line period-1 (all-ones = unknown),
//        o_h_active / o_v_active measured active sizes, o_locked stable-period flag, o_mismatch pulse
module dvp_sync_gen
  import dvp_timing_pkg::*;
#(
  parameter int HCOUNT_BITS = DEF_HCOUNT_BITS,
  parameter int VCOUNT_BITS = DEF_VCOUNT_BITS,
  parameter int HS_FRONT    = DEF_HS_FRONT,
  parameter int HS_WIDTH    = DEF_HS_WIDTH,
  parameter int LOCK_LINES  = DEF_LOCK_LINES,
  parameter int HS_POL      = DEF_HS_POL
) (
  input  logic                   pixclk,
  input  logic                   reset_n,
  input  logic                   vsync,
  input  logic                   href,
  output logic                   o_hsync,
  output logic                   o_de,
  output logic [HCOUNT_BITS-1:0] o_h_total,
  output logic [HCOUNT_BITS-1:0] o_h_active,
  output logic [VCOUNT_BITS-1:0] o_v_active,
  output logic                   o_locked,
  output logic                   o_mismatch
);
  localparam logic [HCOUNT_BITS-1:0] H_ONES = '1;
  localparam logic [HCOUNT_BITS-1:0] H_ONE  = 1;
  localparam logic [HCOUNT_BITS-1:0] FRONT  = HCOUNT_BITS'(HS_FRONT);
  localparam logic [HCOUNT_BITS-1:0] WIDTH  = HCOUNT_BITS'(HS_WIDTH);
  localparam logic [VCOUNT_BITS-1:0] V_ONES = '1;
  localparam logic [VCOUNT_BITS-1:0] V_ONE  = 1;
  localparam logic [MATCH_BITS-1:0]  M_ONES = '1;
  localparam logic [MATCH_BITS-1:0]  M_ONE  = 1;
  localparam logic [MATCH_BITS-1:0]  LOCK_N = MATCH_BITS'(LOCK_LINES);
  state_t state, state_n;
  logic [HCOUNT_BITS-1:0] hs_cnt, hs_cnt_n, h_total_n, h_active_n, meas, set_pt, clr_pt;
  logic [VCOUNT_BITS-1:0] v_cnt, v_cnt_n, v_active_n;
  logic [MATCH_BITS-1:0]  match_cnt, match_cnt_n;
  logic wrapped, wrapped_n, locked_n, mismatch_n, hs_on, hs_on_n, h_act_valid, h_act_valid_n;
  logic href_d1, href_rise, href_fall, vsync_rise, total_valid, at_total;
  dvp_edge_det u_edge (
    .pixclk    (pixclk),
    .reset_n   (reset_n),
    .href      (href),
    .vsync     (vsync),
    .href_d1   (href_d1),
    .href_rise (href_rise),
    .href_fall (href_fall),
    .vsync_rise(vsync_rise)
  );
  assign o_de        = href_d1;
  assign o_hsync     = (HS_POL != 0) ? hs_on : ~hs_on;
  assign total_valid = o_h_total != H_ONES;
  assign at_total    = total_valid && (hs_cnt == o_h_total);
  assign set_pt      = o_h_active + FRONT;
  assign clr_pt      = set_pt + WIDTH;
  // hs_cnt free-runs modulo the known period, so a line longer than o_h_total has
  // wrapped once before its href rise; the true period-1 is then total+1+hs_cnt.
  assign meas        = wrapped ? o_h_total + hs_cnt + H_ONE : hs_cnt;
  always_comb begin
    state_n       = state;
    hs_cnt_n      = at_total ? '0 : (hs_cnt == H_ONES) ? hs_cnt : hs_cnt + H_ONE;
    wrapped_n     = wrapped | at_total;
    h_total_n     = o_h_total;
    h_active_n    = href_fall ? hs_cnt + H_ONE : o_h_active;
    h_act_valid_n = h_act_valid | href_fall;
    v_cnt_n       = v_cnt;
    v_active_n    = o_v_active;
    match_cnt_n   = match_cnt;
    locked_n      = o_locked;
    mismatch_n    = 1'b0;
    if (vsync) begin
      // frame sync overrides any coincident href rise; period and lock survive
      state_n    = SEARCH;
      v_cnt_n    = '0;
      v_active_n = vsync_rise ? v_cnt : o_v_active;
      if (href_rise) begin
        hs_cnt_n  = '0;
        wrapped_n = 1'b0;
      end
    end else if (href_rise) begin
      hs_cnt_n  = '0;
      wrapped_n = 1'b0;
      v_cnt_n   = (v_cnt == V_ONES) ? v_cnt : v_cnt + V_ONE;
      if (state == SEARCH) begin
        state_n = MEASURE;
      end else if (state == MEASURE) begin
        state_n     = RUN;
        h_total_n   = meas;
        match_cnt_n = '0;
      end else if (meas == o_h_total) begin
        match_cnt_n = (match_cnt == M_ONES) ? match_cnt : match_cnt + M_ONE;
        locked_n    = o_locked | (match_cnt_n == LOCK_N);
      end else begin
        mismatch_n  = 1'b1;
        h_total_n   = meas;
        match_cnt_n = '0;
        locked_n    = 1'b0;
      end
    end
    // looks at the next counter value so the registered pulse lines up with hs_cnt
    hs_on_n = (href || !h_act_valid) ? 1'b0 :
              (hs_cnt_n == set_pt)   ? 1'b1 :
              (hs_cnt_n == clr_pt)   ? 1'b0 : hs_on;
  end
  always_ff @(negedge pixclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SEARCH;
      hs_cnt      <= '0;
      wrapped     <= 1'b0;
      o_h_total   <= '1;
      o_h_active  <= '0;
      h_act_valid <= 1'b0;
      v_cnt       <= '0;
      o_v_active  <= '0;
      match_cnt   <= '0;
      o_locked    <= 1'b0;
      o_mismatch  <= 1'b0;
      hs_on       <= 1'b0;
    end else begin
      state       <= state_n;
      hs_cnt      <= hs_cnt_n;
      wrapped     <= wrapped_n;
      o_h_total   <= h_total_n;
      o_h_active  <= h_active_n;
      h_act_valid <= h_act_valid_n;
      v_cnt       <= v_cnt_n;
      o_v_active  <= v_active_n;
      match_cnt   <= match_cnt_n;
      o_locked    <= locked_n;
      o_mismatch  <= mismatch_n;
      hs_on       <= hs_on_n;
    end
  end
endmodule

// File: tb/tb_dvp_sync_gen.sv
// tb_dvp_sync_gen: self-checking bench for dvp_sync_gen (300-clock lines, default parameters)
module tb_dvp_sync_gen;
  import dvp_timing_pkg::*;
  logic pixclk = 1'b0;
  logic reset_n, vsync, href;
  logic o_hsync, o_de, o_locked, o_mismatch;
  logic [11:0] o_h_total, o_h_active;
  logic [10:0] o_v_active;
  int total = 0, bad = 0;
  int mism_seen = 0, hs_rises = 0;
  bit hs_chk = 0;
  typedef struct { int p; int a; int total; int hact; int locked; int mism; } vec_t;
  vec_t tbl[13];
  dvp_sync_gen dut (
    .pixclk    (pixclk),
    .reset_n   (reset_n),
    .vsync     (vsync),
    .href      (href),
    .o_hsync   (o_hsync),
    .o_de      (o_de),
    .o_h_total (o_h_total),
    .o_h_active(o_h_active),
    .o_v_active(o_v_active),
    .o_locked  (o_locked),
    .o_mismatch(o_mismatch)
  );
  always #5 pixclk = ~pixclk;
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // watches sync pulses on the idle (rising) clock edge
  task automatic monitor();
    longint cyc, last_fall, last_rise;
    logic de_q, hs_q, mism_q;
    cyc = 0; last_fall = 0; last_rise = 0;
    de_q = 0; hs_q = 0; mism_q = 0;
    forever begin
      @(posedge pixclk);
      cyc++;
      if (o_hsync === 1'b1 && !hs_q) hs_rises++;
      if (o_mismatch === 1'b1) begin
        chk("mism_width", mism_q, 0);
        mism_seen++;
      end
      if (!hs_chk) begin
        last_fall = 0;
        last_rise = 0;
      end else begin
        if (de_q && !o_de) last_fall = cyc;
        if (o_hsync && !hs_q) begin
          if (last_fall > 0 && cyc - last_fall < 300) chk("hs_front", cyc - last_fall, 110);
          else if (last_rise > 0) chk("hs_period", cyc - last_rise, 300);
          last_rise = cyc;
        end
        if (!o_hsync && hs_q && last_rise > 0) chk("hs_width", cyc - last_rise, 40);
      end
      de_q = o_de; hs_q = o_hsync; mism_q = o_mismatch;
    end
  endtask
  task automatic drive_line(input int p, input int a);
    for (int i = 0; i < p; i++) begin
      @(posedge pixclk);
      href = (i < a);
      vsync = 1'b0;
    end
  endtask
  task automatic blank(input int n, input int vs_at);
    for (int i = 0; i < n; i++) begin
      @(posedge pixclk);
      href = 1'b0;
      vsync = (i >= vs_at) && (i < vs_at + 10);
    end
  endtask
  initial begin
    int base, nl, p, a, prev_p, nrise, m_total, m_run, m_locked, m_mism, m_hact, m_lines;
    tbl[0]  = '{300, 128, 4095, 128, 0, 0};
    tbl[1]  = '{300, 128,  299, 128, 0, 0};
    tbl[2]  = '{300, 128,  299, 128, 0, 0};
    tbl[3]  = '{300, 128,  299, 128, 0, 0};
    tbl[4]  = '{300, 128,  299, 128, 0, 0};
    tbl[5]  = '{300, 128,  299, 128, 1, 0};
    tbl[6]  = '{301, 128,  299, 128, 1, 0};
    tbl[7]  = '{300, 100,  300, 100, 0, 1};
    tbl[8]  = '{300, 128,  299, 128, 0, 2};
    tbl[9]  = '{300, 128,  299, 128, 0, 2};
    tbl[10] = '{300, 128,  299, 128, 0, 2};
    tbl[11] = '{300, 128,  299, 128, 0, 2};
    tbl[12] = '{300, 128,  299, 128, 1, 2};
    reset_n = 1'b1; href = 1'b0; vsync = 1'b0;
    fork
      monitor();
    join_none
    #1 reset_n = 1'b0;
    repeat (3) @(posedge pixclk);
    #1;
    chk("rst_total", o_h_total, 4095);
    chk("rst_hact", o_h_active, 0);
    chk("rst_vact", o_v_active, 0);
    chk("rst_locked", o_locked, 0);
    chk("rst_mism", o_mismatch, 0);
    chk("rst_de", o_de, 0);
    chk("rst_hsync", o_hsync, 0);
    chk("rst_state", int'(dut.state), int'(SEARCH));
    @(posedge pixclk);
    reset_n = 1'b1;
    base = hs_rises;
    blank(4200, 4200);
    chk("idle_hsync", hs_rises - base, 0);
    chk("idle_hs_sat", dut.hs_cnt, 4095);
    chk("idle_total", o_h_total, 4095);
    base = mism_seen;
    foreach (tbl[i]) begin
      drive_line(tbl[i].p, tbl[i].a);
      chk($sformatf("tbl%0d_total", i), o_h_total, tbl[i].total);
      chk($sformatf("tbl%0d_hact", i), o_h_active, tbl[i].hact);
      chk($sformatf("tbl%0d_locked", i), o_locked, tbl[i].locked);
      chk($sformatf("tbl%0d_mism", i), mism_seen - base, tbl[i].mism);
    end
    base = mism_seen;
    @(posedge pixclk);
    href = 1'b1; vsync = 1'b1;
    @(posedge pixclk);
    chk("col_hs_cnt", dut.hs_cnt, 0);
    chk("col_state", int'(dut.state), int'(SEARCH));
    chk("col_locked", o_locked, 1);
    chk("col_vact", o_v_active, 13);
    for (int i = 1; i < 299; i++) begin
      vsync = (i < 10);
      href = (i < 128);
      @(posedge pixclk);
    end
    href = 1'b0; vsync = 1'b0;
    chk("col_mism", mism_seen - base, 0);
    chk("col_total", o_h_total, 299);
    for (int f = 0; f < 3; f++) begin
      blank(300, 100);
      if (f > 0) chk($sformatf("frm%0d_vact", f), o_v_active, 12);
      for (int l = 0; l < 12; l++) begin
        drive_line(300, 128);
        if (f == 0 && l == 0) hs_chk = 1;
      end
      chk($sformatf("frm%0d_total", f), o_h_total, 299);
      chk($sformatf("frm%0d_hact", f), o_h_active, 128);
      chk($sformatf("frm%0d_locked", f), o_locked, 1);
    end
    blank(300, 100);
    hs_chk = 0;
    chk("frm3_vact", o_v_active, 12);
    repeat (3) drive_line(300, 128);
    drive_line(150, 128);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_total", o_h_total, 4095);
    chk("ar_hact", o_h_active, 0);
    chk("ar_vact", o_v_active, 0);
    chk("ar_locked", o_locked, 0);
    chk("ar_mism", o_mismatch, 0);
    chk("ar_de", o_de, 0);
    chk("ar_hsync", o_hsync, 0);
    repeat (3) @(posedge pixclk);
    reset_n = 1'b1;
    blank(150, 150);
    drive_line(300, 128);
    chk("ar_first_total", o_h_total, 4095);
    drive_line(300, 128);
    chk("ar_second_total", o_h_total, 299);
    chk("ar_second_locked", o_locked, 0);
    @(posedge pixclk);
    reset_n = 1'b0;
    repeat (2) @(posedge pixclk);
    reset_n = 1'b1;
    base = mism_seen;
    m_total = 4095; m_run = 0; m_locked = 0; m_mism = 0; m_hact = 0; m_lines = 0; prev_p = 0;
    for (int f = 0; f < 4; f++) begin
      blank(100 + int'($urandom_range(0, 300)), 40);
      chk($sformatf("rnd%0d_vact", f), o_v_active, m_lines);
      m_lines = 0;
      nrise = 0;
      nl = int'($urandom_range(5, 12));
      for (int l = 0; l < nl; l++) begin
        p = ($urandom_range(0, 3) != 0) ? 300 : 290 + int'($urandom_range(0, 20));
        a = int'($urandom_range(20, p - 30));
        nrise++;
        m_lines++;
        if (nrise == 2) begin
          m_total = prev_p - 1;
          m_run = 0;
        end else if (nrise > 2) begin
          if (prev_p - 1 == m_total) begin
            m_run++;
            if (m_run == 4) m_locked = 1;
          end else begin
            m_mism++;
            m_total = prev_p - 1;
            m_run = 0;
            m_locked = 0;
          end
        end
        drive_line(p, a);
        m_hact = a;
        chk($sformatf("rnd%0d_%0d_total", f, l), o_h_total, m_total);
        chk($sformatf("rnd%0d_%0d_locked", f, l), o_locked, m_locked);
        chk($sformatf("rnd%0d_%0d_hact", f, l), o_h_active, m_hact);
        chk($sformatf("rnd%0d_%0d_mism", f, l), mism_seen - base, m_mism);
        prev_p = p;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
